pll_reset_sequencer: RTL and testbench
======================================

# pll_reset_sequencer

Reset and lock supervisor that sits directly downstream of the system PLL. It runs on the free-running reference clock and drives the PLL reset. It watches the PLL `locked` flag, qualifies a stable lock, and releases per-domain reset requests one at a time in fixed order. Loss of lock re-asserts all domain resets. A PLL that fails to lock within a timeout is re-reset.

## Interface
Parameters:
- `PLL_RST_CYCLES`, 16: width of the `pll_rst` pulse in clk cycles (≥1).
- `LOCK_STABLE_CYCLES`, 1024: consecutive synchronized-lock cycles required before release (≥1).
- `LOCK_TIMEOUT_CYCLES`, 1000000: cycles waited for lock before re-pulsing `pll_rst` (≥1).
- `RELEASE_GAP`, 8: cycles between successive domain reset releases (≥1).
- `N_DOMAINS`, 3: number of domain reset outputs (≥1).

Ports:
- `clk`  in  1  free-running 50 MHz reference clock (the same net as the PLL reference input).
- `rst`  in  1  reset; asynchronous, active-high.
- `locked`  in  1  PLL lock flag; asynchronous to `clk`.
- `pll_rst`  out  1  reset to the PLL, active-high.
- `domain_rst`  out  N_DOMAINS  per-domain reset requests, active-high. Each destination domain resynchronizes its own bit.
- `ready`  out  1  high when all domain resets are released.
- `relock_count`  out  8  count of lock-loss events, saturating.

## Operation
- All outputs are registered.
- Reset values:
  - `pll_rst`=1
  - `domain_rst`=all 1
  - `ready`=0
  - `relock_count`=0
  - state=PLL_RESET, counter=0
  - synchronizer flops=0
- `locked` passes through a 2-flop synchronizer, giving `locked_sync`. One shared counter is used; its width is clog2 of the largest cycle parameter.
- PLL_RESET: `pll_rst`=1 and the counter increments. When counter==PLL_RST_CYCLES-1, go to WAIT_LOCK, set `pll_rst`=0, clear the counter.
- WAIT_LOCK:
  - If `locked_sync`=1, go to STABLE and clear the counter.
  - Otherwise the counter increments. When counter==LOCK_TIMEOUT_CYCLES-1, go to PLL_RESET with `pll_rst`=1 and the counter cleared.
- STABLE:
  - If `locked_sync`=0, go to WAIT_LOCK and clear the counter. No count increment.
  - If `locked_sync`=1 and counter==LOCK_STABLE_CYCLES-1, go to RELEASE, clear `domain_rst[0]`, clear the counter, set idx=1.
- RELEASE:
  - The counter increments. When counter==RELEASE_GAP-1, clear `domain_rst[idx]`, increment idx, clear the counter.
  - The edge that clears `domain_rst[N_DOMAINS-1]` also sets `ready`=1 and enters RUN.
  - If N_DOMAINS=1, STABLE goes straight to RUN with `ready`=1.
- RUN: holds until `locked_sync`=0.
- Lock loss (`locked_sync`=0 in RELEASE or RUN), all on the next edge:
  - `domain_rst`=all 1, `ready`=0
  - `relock_count` increments, saturating at 255
  - go to WAIT_LOCK, counter cleared
  - `pll_rst` stays 0
- Lock loss in STABLE or WAIT_LOCK does not increment `relock_count`.
- Asserting `rst` at any time, including mid-RELEASE or mid-pulse, forces the reset values immediately, without a clock edge.

## Timing
- `pll_rst` is high for exactly PLL_RST_CYCLES edges after `rst` deassertion, then falls.
- Lock to release: let edge e0 be the first edge sampling `locked`=1.
  - STABLE is entered at e0+2.
  - `domain_rst[0]` falls at e0+2+LOCK_STABLE_CYCLES.
  - `domain_rst[i]` falls i·RELEASE_GAP edges after `domain_rst[0]`.
  - `ready` rises on the same edge as `domain_rst[N_DOMAINS-1]`.
- Lock loss to reset: `domain_rst` is re-asserted 3 edges after `locked` falls (2 synchronizer edges + 1).
- A `locked` pulse shorter than one cycle may be missed; this is acceptable.
- Timeout period without lock: `pll_rst` pulses PLL_RST_CYCLES high every PLL_RST_CYCLES+LOCK_TIMEOUT_CYCLES cycles.

## Test plan
Parameters for all tests: PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, RELEASE_GAP=2, N_DOMAINS=3.
- **Clean lock.** Release `rst`, raise `locked` at cycle 10 (e0) and hold it.
  - `pll_rst` is high for edges 1–4.
  - `domain_rst` goes 3'b110 at e0+10, 3'b100 at e0+12, 3'b000 at e0+14.
  - `ready`=1 at e0+14.
  - `relock_count`=0.
- **Glitch during STABLE.** Drop `locked` for 3 cycles at e0+5.
  - Release is delayed; `domain_rst[0]` falls 10 edges after the first edge re-sampling `locked`=1.
  - `relock_count`=0.
- **Never locks.** Hold `locked`=0.
  - `pll_rst` pulses 4 high every 36 cycles.
  - `domain_rst` stays 3'b111 and `ready` stays 0.
- **Lock loss in RUN.** Drop `locked` after `ready`=1.
  - `domain_rst`=3'b111 and `ready`=0 three edges later.
  - `relock_count`=1.
  - Re-lock repeats the clean-lock release sequence.
  - 300 loss events leave `relock_count`=255.
- **Asynchronous reset mid-RELEASE.** Assert `rst` between clk edges while `domain_rst`=3'b110.
  - `pll_rst`=1, `domain_rst`=3'b111, `ready`=0 and `relock_count`=0 immediately.
  - The sequence restarts from PLL_RESET on `rst` release.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// PLL reset and lock supervisor: pulses the PLL reset, qualifies lock,
// then releases domain resets one at a time in fixed order.
module pll_reset_sequencer #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 1000000,
  parameter int RELEASE_GAP         = 8,
  parameter int N_DOMAINS           = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 locked,
  output logic                 pll_rst,
  output logic [N_DOMAINS-1:0] domain_rst,
  output logic                 ready,
  output logic [7:0]           relock_count
);

  localparam int M0 = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ?
                      PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int M1 = (LOCK_TIMEOUT_CYCLES > RELEASE_GAP) ?
                      LOCK_TIMEOUT_CYCLES : RELEASE_GAP;
  localparam int MAXC = (M0 > M1) ? M0 : M1;
  localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int IW = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;

  localparam logic [CW-1:0] PR_LAST  = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] ST_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(RELEASE_GAP - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_DOMAINS - 1);
  localparam logic [N_DOMAINS-1:0] ONE = N_DOMAINS'(1);

  localparam logic [2:0] PLL_RESET = 3'd0;
  localparam logic [2:0] WAIT_LOCK = 3'd1;
  localparam logic [2:0] STABLE    = 3'd2;
  localparam logic [2:0] RELEASE   = 3'd3;
  localparam logic [2:0] RUN       = 3'd4;

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [1:0]    sync;
  logic          locked_sync;
  logic          lock_lost;

  assign locked_sync = sync[1];
  // Only a loss after release has begun counts as a relock event
  assign lock_lost = !locked_sync &&
                     (state == RELEASE || state == RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync         <= '0;
      state        <= PLL_RESET;
      cnt          <= '0;
      idx          <= '0;
      pll_rst      <= 1'b1;
      domain_rst   <= '1;
      ready        <= 1'b0;
      relock_count <= '0;
    end else begin
      sync <= {sync[0], locked};
      if (lock_lost) begin
        domain_rst <= '1;
        ready      <= 1'b0;
        state      <= WAIT_LOCK;
        cnt        <= '0;
        if (relock_count != 8'hFF)
          relock_count <= relock_count + 8'd1;
      end else begin
        unique case (state)
          PLL_RESET: begin
            if (cnt == PR_LAST) begin
              state   <= WAIT_LOCK;
              pll_rst <= 1'b0;
              cnt     <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          WAIT_LOCK: begin
            if (locked_sync) begin
              state <= STABLE;
              cnt   <= '0;
            end else if (cnt == TO_LAST) begin
              state   <= PLL_RESET;
              pll_rst <= 1'b1;
              cnt     <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          STABLE: begin
            if (!locked_sync) begin
              state <= WAIT_LOCK;
              cnt   <= '0;
            end else if (cnt == ST_LAST) begin
              cnt <= '0;
              if (N_DOMAINS == 1) begin
                domain_rst <= '0;
                ready      <= 1'b1;
                state      <= RUN;
              end else begin
                domain_rst[0] <= 1'b0;
                idx           <= IW'(1);
                state         <= RELEASE;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          RELEASE: begin
            if (cnt == GAP_LAST) begin
              domain_rst <= domain_rst & ~(ONE << idx);
              cnt        <= '0;
              if (idx == IDX_LAST) begin
                ready <= 1'b1;
                state <= RUN;
              end else begin
                idx <= idx + 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          RUN: begin
            state <= RUN;
          end
          default: begin
            state   <= PLL_RESET;
            pll_rst <= 1'b1;
            cnt     <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: vector table, corner sequences,
// and random lock activity against a timeline model.
module tb_pll_reset_sequencer;

  localparam int PR  = 4;
  localparam int ST  = 8;
  localparam int TO  = 32;
  localparam int GAP = 2;
  localparam int ND  = 3;
  localparam int REL0 = 1 + ST;

  logic          clk = 1'b0;
  logic          rst;
  logic          locked;
  logic          pll_rst;
  logic [ND-1:0] domain_rst;
  logic          ready;
  logic [7:0]    relock_count;

  int total = 0;
  int bad   = 0;
  int k     = 0;

  always #5 clk = ~clk;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES(PR),
    .LOCK_STABLE_CYCLES(ST),
    .LOCK_TIMEOUT_CYCLES(TO),
    .RELEASE_GAP(GAP),
    .N_DOMAINS(ND)
  ) dut (
    .clk(clk),
    .rst(rst),
    .locked(locked),
    .pll_rst(pll_rst),
    .domain_rst(domain_rst),
    .ready(ready),
    .relock_count(relock_count)
  );

  typedef struct {
    int         hold;
    logic       lk;
    logic       pll;
    logic [2:0] dom;
    logic       rdy;
    logic [7:0] rc;
  } vec_t;

  vec_t vecs[$];

  // timeline model: lock age in edges decides which resets are released
  bit m_pulse;
  int m_p, m_w, m_a, m_rc;
  bit m_hist[$];

  task automatic tick();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic chk(input string nm, input logic p,
                     input logic [ND-1:0] d, input logic r,
                     input logic [7:0] c);
    total++;
    if (pll_rst !== p || domain_rst !== d ||
        ready !== r || relock_count !== c) begin
      bad++;
      $display("FAIL %s k=%0d got pll_rst=%b domain_rst=%b ready=%b relock=%0d want %b %b %b %0d",
               nm, k, pll_rst, domain_rst, ready, relock_count,
               p, d, r, c);
    end
  endtask

  function automatic void m_reset();
    m_pulse = 1'b1;
    m_p = 0;
    m_w = 0;
    m_a = 0;
    m_rc = 0;
    m_hist.delete();
  endfunction

  function automatic void m_edge(input bit lk);
    bit ls;
    m_hist.push_back(lk);
    ls = (m_hist.size() >= 3) ? m_hist[m_hist.size()-3] : 1'b0;
    if (m_hist.size() > 4) void'(m_hist.pop_front());
    if (m_pulse) begin
      m_p++;
      if (m_p == PR) begin
        m_pulse = 1'b0;
        m_w = 0;
      end
    end else if (ls) begin
      if (m_a < 1000) m_a++;
    end else if (m_a > 0) begin
      if (m_a >= REL0 && m_rc < 255) m_rc++;
      m_a = 0;
      m_w = 0;
    end else begin
      m_w++;
      if (m_w == TO) begin
        m_pulse = 1'b1;
        m_p = 0;
      end
    end
  endfunction

  task automatic m_chk();
    logic [ND-1:0] d;
    for (int i = 0; i < ND; i++)
      d[i] = !(m_a >= REL0 + i * GAP);
    chk("random", m_pulse, d, m_a >= REL0 + (ND - 1) * GAP,
        8'(m_rc));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    locked = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset", 1'b1, 3'b111, 1'b0, 8'd0);
    rst = 1'b0;
    k = 0;
  endtask

  initial begin
    rst = 1'b1;
    locked = 1'b0;

    // clean lock (e0=10), then loss in RUN and relock
    vecs.push_back('{1, 1'b0, 1'b1, 3'b111, 1'b0, 8'd0});
    vecs.push_back('{2, 1'b0, 1'b1, 3'b111, 1'b0, 8'd0});
    vecs.push_back('{1, 1'b0, 1'b0, 3'b111, 1'b0, 8'd0});
    vecs.push_back('{5, 1'b0, 1'b0, 3'b111, 1'b0, 8'd0});
    vecs.push_back('{10, 1'b1, 1'b0, 3'b111, 1'b0, 8'd0});
    vecs.push_back('{1, 1'b1, 1'b0, 3'b110, 1'b0, 8'd0});
    vecs.push_back('{1, 1'b1, 1'b0, 3'b110, 1'b0, 8'd0});
    vecs.push_back('{1, 1'b1, 1'b0, 3'b100, 1'b0, 8'd0});
    vecs.push_back('{1, 1'b1, 1'b0, 3'b100, 1'b0, 8'd0});
    vecs.push_back('{1, 1'b1, 1'b0, 3'b000, 1'b1, 8'd0});
    vecs.push_back('{6, 1'b1, 1'b0, 3'b000, 1'b1, 8'd0});
    vecs.push_back('{2, 1'b0, 1'b0, 3'b000, 1'b1, 8'd0});
    vecs.push_back('{1, 1'b0, 1'b0, 3'b111, 1'b0, 8'd1});
    vecs.push_back('{10, 1'b1, 1'b0, 3'b111, 1'b0, 8'd1});
    vecs.push_back('{1, 1'b1, 1'b0, 3'b110, 1'b0, 8'd1});
    vecs.push_back('{4, 1'b1, 1'b0, 3'b000, 1'b1, 8'd1});

    do_reset();
    foreach (vecs[i]) begin
      locked = vecs[i].lk;
      repeat (vecs[i].hold) tick();
      chk($sformatf("vec%0d", i), vecs[i].pll, vecs[i].dom,
          vecs[i].rdy, vecs[i].rc);
    end

    // repeated losses saturate the relock counter
    for (int e = 0; e < 300; e++) begin
      locked = 1'b0;
      repeat (4) tick();
      locked = 1'b1;
      repeat (18) tick();
      chk("sat", 1'b0, 3'b000, 1'b1, 8'((e + 2 > 255) ? 255 : e + 2));
    end

    // asynchronous reset while partly released
    locked = 1'b0;
    repeat (4) tick();
    locked = 1'b1;
    repeat (11) tick();
    chk("pre_async", 1'b0, 3'b110, 1'b0, 8'd255);
    #2;
    rst = 1'b1;
    locked = 1'b0;
    #1;
    chk("async_rst", 1'b1, 3'b111, 1'b0, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    k = 0;

    // restart and never lock: pll_rst pulses 4 of every 36 edges
    for (int i = 1; i <= 110; i++) begin
      tick();
      chk("nolock", (k % (PR + TO)) < PR, 3'b111, 1'b0, 8'd0);
    end

    // glitch while qualifying lock delays release
    do_reset();
    repeat (9) tick();
    locked = 1'b1;
    repeat (5) tick();
    locked = 1'b0;
    repeat (3) tick();
    locked = 1'b1;
    repeat (10) tick();
    chk("glitch27", 1'b0, 3'b111, 1'b0, 8'd0);
    tick();
    chk("glitch28", 1'b0, 3'b110, 1'b0, 8'd0);
    repeat (4) tick();
    chk("glitch32", 1'b0, 3'b000, 1'b1, 8'd0);

    // random lock activity against the model
    do_reset();
    while (k < 3000) begin
      bit lv;
      int len;
      lv = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 45);
      locked = lv;
      for (int j = 0; j < len; j++) begin
        tick();
        m_edge(lv);
        m_chk();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
